// File: rtl/imem_boot_loader_pkg.sv
// Shared constants for the instruction-memory boot loader: state encoding and frame layout.
// Optional checksum trailer is enabled by IMEM_BOOT_CHECKSUM_EN.
package imem_boot_loader_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_HDR_LO = 3'd0;
    localparam state_t ST_HDR_HI = 3'd1;
    localparam state_t ST_DATA   = 3'd2;
    localparam state_t ST_CSUM   = 3'd3;
    localparam state_t ST_DONE   = 3'd4;
    localparam state_t ST_ERR    = 3'd5;

    localparam int HDR_BYTES = 2;
    localparam int CSUM_W    = 8;

    function automatic logic rx_state(input state_t s);
        return (s == ST_HDR_LO) || (s == ST_HDR_HI) || (s == ST_DATA) || (s == ST_CSUM);
    endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream input handshake plus the instruction-memory write port of the boot loader.
interface imem_boot_loader_if #(parameter int ADDR_W = 8);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (output in_data, in_valid,
                    input  in_ready, imem_we, imem_addr, imem_wdata);
    modport slave  (input  in_data, in_valid,
                    output in_ready, imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/imem_word_packer.sv
// Packs accepted bytes little-endian into 32-bit words and issues a one-cycle write per word.
module imem_word_packer
    import imem_boot_loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              accept,
    input  logic [7:0]        byte_in,
    input  logic [ADDR_W-1:0] addr_in,
    output logic              word_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata
);

    logic [1:0]      byte_idx;
    logic [2:0][7:0] lanes;

    // Byte 3 goes straight into the write word, so only three lanes are held.
    assign word_last = accept && (byte_idx == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_idx   <= '0;
            lanes      <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else if (clr) begin
            byte_idx <= '0;
            lanes    <= '0;
            imem_we  <= 1'b0;
        end else begin
            imem_we <= word_last;
            if (accept) begin
                byte_idx <= byte_idx + 2'd1;
                for (int k = 0; k < 3; k++)
                    if (byte_idx == 2'(k)) lanes[k] <= byte_in;
            end
            if (word_last) begin
                imem_wdata <= {byte_in, lanes};
                imem_addr  <= addr_in;
            end
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: parses a count-prefixed byte frame, writes words to imem, holds the core in reset.
// Define IMEM_BOOT_CHECKSUM_EN to require an XOR checksum byte after the payload.
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    imem_boot_loader_if.slave bus,
    input  logic              reload,
    output logic              cpu_rst,
    output logic              done,
    output logic              error
);

    localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_W);
`ifdef IMEM_BOOT_CHECKSUM_EN
    localparam state_t ST_TAIL = ST_CSUM;
`else
    localparam state_t ST_TAIL = ST_DONE;
`endif

    state_t      state;
    logic [7:0]  cnt_lo;
    logic [15:0] n_words;
    logic [15:0] word_idx;
    logic [15:0] hdr_n;
    logic        xfer, data_acc, rearm, word_last;

    assign bus.in_ready = rx_state(state);
    assign xfer         = bus.in_valid && bus.in_ready;
    assign data_acc     = xfer && (state == ST_DATA);
    assign rearm        = reload && ((state == ST_DONE) || (state == ST_ERR));
    assign hdr_n        = {bus.in_data, cnt_lo};
    assign done         = (state == ST_DONE);
    assign error        = (state == ST_ERR);

`ifdef IMEM_BOOT_CHECKSUM_EN
    logic [CSUM_W-1:0] csum;
    always_ff @(posedge clk) begin
        if (rst || state == ST_HDR_LO) csum <= '0;
        else if (data_acc)             csum <= csum ^ bus.in_data;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_HDR_LO;
            cnt_lo   <= '0;
            n_words  <= '0;
            word_idx <= '0;
            cpu_rst  <= 1'b1;
        end else begin
            // Registered release gives the core one more reset cycle after the last write.
            cpu_rst <= rearm ? 1'b1 : (state != ST_DONE);
            case (state)
                ST_HDR_LO: if (xfer) begin
                    cnt_lo <= bus.in_data;
                    state  <= ST_HDR_HI;
                end
                ST_HDR_HI: if (xfer) begin
                    n_words <= hdr_n;
                    if ({1'b0, hdr_n} > MAX_WORDS) state <= ST_ERR;
                    else if (hdr_n == 16'd0)       state <= ST_TAIL;
                    else                           state <= ST_DATA;
                end
                ST_DATA: if (word_last) begin
                    word_idx <= word_idx + 16'd1;
                    if (word_idx == n_words - 16'd1) state <= ST_TAIL;
                end
`ifdef IMEM_BOOT_CHECKSUM_EN
                ST_CSUM: if (xfer)
                    state <= (bus.in_data == csum) ? ST_DONE : ST_ERR;
`endif
                ST_DONE, ST_ERR: if (reload) begin
                    state    <= ST_HDR_LO;
                    cnt_lo   <= '0;
                    n_words  <= '0;
                    word_idx <= '0;
                end
                default: state <= ST_ERR;
            endcase
        end
    end

    imem_word_packer #(.ADDR_W(ADDR_W)) u_packer (
        .clk        (clk),
        .rst        (rst),
        .clr        (rearm),
        .accept     (data_acc),
        .byte_in    (bus.in_data),
        .addr_in    (word_idx[ADDR_W-1:0]),
        .word_last  (word_last),
        .imem_we    (bus.imem_we),
        .imem_addr  (bus.imem_addr),
        .imem_wdata (bus.imem_wdata)
    );

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Upstream of the RISC-V processor core.
- Receives a byte stream on a valid/ready handshake, packs the bytes into 32-bit little-endian instruction words and writes them sequentially into instruction memory.
- Holds the core in reset until the image has loaded.
- Lets the bench or a UART front-end load programs without rebuilding memory init files.

Parameters:
- ADDR_W, 8: instruction-memory word-address width; capacity is 2^ADDR_W words.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  loader accepts a byte this cycle.
- reload  input  1  pulse to re-arm the loader after DONE or ERR.
- imem_we  output  1  instruction-memory write strobe (one cycle per word).
- imem_addr  output  ADDR_W  word address for the write.
- imem_wdata  output  32  instruction word for the write.
- cpu_rst  output  1  reset to the processor core; high until the load completes.
- done  output  1  image loaded successfully.
- error  output  1  load aborted.

Behaviour:
- A byte transfers on a cycle where in_valid && in_ready are both high. in_data is sampled only on a transfer.
- Frame format:
  - WCNT_LO, then WCNT_HI: a 16-bit word count N.
  - 4*N payload bytes, each word least-significant byte first.
- State machine states: HDR_LO, HDR_HI, DATA, DONE, ERR. CSUM is added when the option is enabled.
- On reset:
  - state=HDR_LO; byte and word counters = 0.
  - imem_we=0, imem_addr=0, imem_wdata=0.
  - cpu_rst=1, done=0, error=0.
- in_ready is 1 in HDR_LO, HDR_HI, DATA and CSUM; it is 0 in DONE and ERR.
- HDR_LO: on transfer, latch the low count byte and go to HDR_HI.
- HDR_HI: on transfer, form N and branch:
  - N > 2^ADDR_W: go to ERR.
  - N == 0: go to DONE (CSUM when enabled).
  - Otherwise: go to DATA.
- DATA:
  - A 2-bit byte index shifts each byte into its lane (byte k -> bits 8k+7:8k).
  - On the transfer of byte index 3:
    - Next cycle imem_we=1 for exactly one cycle.
    - imem_wdata = the assembled word; imem_addr = word index (starting at 0).
    - The word index then increments.
  - After word N-1 is accepted, go to DONE (CSUM when enabled).
  - Back-to-back transfers are legal: one byte per cycle, with no stall while imem_we is asserted.
- DONE:
  - done=1 from the first cycle in DONE.
  - cpu_rst is registered: it falls to 0 on the cycle after DONE is entered, so the core sees at least one reset cycle after the last imem write.
- ERR: error=1 and cpu_rst stays 1.
- reload:
  - Honoured only in DONE or ERR.
  - Returns to HDR_LO next cycle; clears done, error and the counters; reasserts cpu_rst=1 immediately (same registered update).
  - reload in any other state is ignored.
- rst mid-load:
  - Aborts the load; all outputs return to reset values next cycle.
  - Partially written memory contents are not cleared.
- imem_addr never wraps: the N bound guarantees the last address is 2^ADDR_W-1.

Optional Feature:
- Macro: IMEM_BOOT_CHECKSUM_EN.
- When defined:
  - One CSUM byte follows the payload (and follows the header when N=0).
  - Its value is the XOR of all payload bytes; the running XOR resets in HDR_LO.
  - Match: go to DONE. Mismatch: go to ERR.
  - Words already written remain in memory, but cpu_rst stays high.
- When not defined: no CSUM state; the last payload byte (or a zero count) leads directly to DONE.

Decomposition:
- Shared package holds:
  - the state encoding typedef/localparams (HDR_LO=0, HDR_HI=1, DATA=2, CSUM=3, DONE=4, ERR=5);
  - the frame header byte count (2);
  - the checksum width constant (8).
- One natural sub-module: imem_word_packer.
  - Contains the 2-bit byte index, the 32-bit shift/lane register and the write-strobe generation.
  - The FSM in imem_boot_loader drives its byte-accept and clear inputs.

Test Plan:
- N=2, bytes 02 00 | 13 05 10 00 | 93 05 20 00 at one byte per cycle, then:
  - imem_we pulses at addr 0 with 0x00100513, then at addr 1 with 0x00200593;
  - done=1; cpu_rst falls 1 cycle after done rises.
- Same frame with in_valid toggled every other cycle -> identical writes; no extra imem_we pulses; in_ready stays 1 in DATA.
- Header 01 01 (N=257) with ADDR_W=8 -> ERR; error=1; in_ready=0; cpu_rst=1; no imem_we.
- Header 00 00 -> done=1 with zero writes; a following reload pulse -> done=0, cpu_rst=1, in_ready=1 next cycle.
- rst asserted after the 6th byte of an N=2 load -> outputs return to reset values; a fresh N=1 frame then writes addr 0 correctly.
- With IMEM_BOOT_CHECKSUM_EN:
  - N=1 word 0x00000013 then CSUM 0x13 -> DONE.
  - Same frame with CSUM 0x12 -> ERR; cpu_rst stays 1.
